// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the conv-engine ADD sequencer: state encoding,
// default geometry, row-select helpers and the request legality rule.
package add_seq_ctrl_pkg;

  localparam int unsigned DEF_ROWS    = 8;
  localparam int unsigned DEF_ACC_ROW = 7;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Widest row select any engine instantiates; onehot() results are cast down.
  localparam int unsigned MAX_ROWS = 64;
  localparam logic [MAX_ROWS-1:0] ROW_ONE = {{(MAX_ROWS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } seq_state_e;

  function automatic logic [MAX_ROWS-1:0] onehot(input int unsigned idx);
    return (idx < MAX_ROWS) ? (ROW_ONE << idx) : '0;
  endfunction

  function automatic logic reqRejected(input int unsigned baseRow,
                                       input int unsigned numTerms,
                                       input int unsigned rows,
                                       input int unsigned accRow);
    logic tooFew;
    logic overrun;
    logic hitsAcc;
    tooFew  = (numTerms < 2);
    overrun = ((baseRow + numTerms) > rows);
    hitsAcc = (accRow >= baseRow) && (accRow < (baseRow + numTerms));
    return tooFew || overrun || hitsAcc;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_timeout.sv
// Loadable down-counter with an expiry flag; shared by the engine sequencers
// to bound how long they wait on a downstream DONE.
module add_seq_timeout #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrementing saturates at zero so expiry stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/add_seq_ctrl.sv
// Reduces a contiguous run of partial-sum rows into the accumulator row by
// issuing one ADD word-line operation at a time and waiting for its DONE.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned ACC_ROW = DEF_ACC_ROW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [$clog2(ROWS)-1:0] base_row_i,
  input  logic [$clog2(ROWS):0]   num_terms_i,
  input  logic                    add_done_i,
  output logic                    add_en_o,
  output logic [ROWS-1:0]         src_a_sel_o,
  output logic [ROWS-1:0]         src_b_sel_o,
  output logic [ROWS-1:0]         dst_sel_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned NW = RW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT - 1);

  seq_state_e state_q, state_d;

  logic [RW-1:0]   baseRow_q, baseRow_d;
  logic [NW-1:0]   numTerms_q, numTerms_d;
  logic [NW-1:0]   opCnt_q, opCnt_d;
  logic [ROWS-1:0] srcA_q, srcA_d;
  logic [ROWS-1:0] srcB_q, srcB_d;
  logic [ROWS-1:0] dst_q, dst_d;
  logic            addEn_q, addEn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            tmrLoad;
  logic            tmrDec;
  logic            tmrExpired;

  int unsigned     idxA;
  int unsigned     idxB;
  logic [ROWS-1:0] opSelA;
  logic [ROWS-1:0] opSelB;
  logic [ROWS-1:0] accSel;
  logic            lastOp;
  logic            rejected;

  // Operand rows for op k = opCnt_q: the first op pairs the two lowest rows,
  // every later op folds the next row into the running accumulator.
  assign idxA     = (opCnt_q == '0) ? 32'(baseRow_q) : ACC_ROW;
  assign idxB     = 32'(baseRow_q) + 32'(opCnt_q) + 32'd1;
  assign opSelA   = ROWS'(onehot(idxA));
  assign opSelB   = ROWS'(onehot(idxB));
  assign accSel   = ROWS'(onehot(ACC_ROW));
  assign lastOp   = (opCnt_q == (numTerms_q - 1'b1));
  assign rejected = reqRejected(32'(baseRow_q), 32'(numTerms_q), ROWS, ACC_ROW);

  add_seq_timeout #(
    .W (CW)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmrLoad),
    .load_val_i (TMR_LOAD),
    .dec_i      (tmrDec),
    .expired_o  (tmrExpired)
  );

  always_comb begin
    state_d    = state_q;
    baseRow_d  = baseRow_q;
    numTerms_d = numTerms_q;
    opCnt_d    = opCnt_q;
    srcA_d     = srcA_q;
    srcB_d     = srcB_q;
    dst_d      = dst_q;
    addEn_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmrLoad    = 1'b0;
    tmrDec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          baseRow_d  = base_row_i;
          numTerms_d = num_terms_i;
          opCnt_d    = '0;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rejected) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          srcA_d  = opSelA;
          srcB_d  = opSelB;
          dst_d   = accSel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmrLoad = 1'b1;
        addEn_d = 1'b1;
        state_d = ST_WAIT;
      end
      // add_done is checked before expiry so a DONE on the last allowed cycle wins.
      ST_WAIT: begin
        tmrDec = 1'b1;
        if (add_done_i) begin
          opCnt_d = opCnt_q + 1'b1;
          state_d = ST_GAP;
        end else if (tmrExpired) begin
          err_d   = 1'b1;
          srcA_d  = '0;
          srcB_d  = '0;
          dst_d   = '0;
          state_d = ST_IDLE;
        end else begin
          addEn_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (lastOp) begin
          done_d  = 1'b1;
          srcA_d  = '0;
          srcB_d  = '0;
          dst_d   = '0;
          state_d = ST_FINISH;
        end else begin
          srcA_d  = opSelA;
          srcB_d  = opSelB;
          dst_d   = accSel;
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baseRow_q  <= '0;
      numTerms_q <= '0;
      opCnt_q    <= '0;
      srcA_q     <= '0;
      srcB_q     <= '0;
      dst_q      <= '0;
      addEn_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baseRow_q  <= baseRow_d;
      numTerms_q <= numTerms_d;
      opCnt_q    <= opCnt_d;
      srcA_q     <= srcA_d;
      srcB_q     <= srcB_d;
      dst_q      <= dst_d;
      addEn_q    <= addEn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign add_en_o    = addEn_q;
  assign src_a_sel_o = srcA_q;
  assign src_b_sel_o = srcB_q;
  assign dst_sel_o   = dst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: requests are expanded into expected op,
// done and err events from the reduction rules; a monitor pops and compares.
module tb_add_seq_ctrl;

  localparam int ROWS    = 8;
  localparam int ACC     = 7;
  localparam int TIMEOUT = 64;
  localparam int EV_OP   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] baseRow = '0;
  logic [3:0] numTerms = '0;
  logic       addDone = 1'b0;
  logic       addEn;
  logic [7:0] selA;
  logic [7:0] selB;
  logic [7:0] selD;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct {
    int kind;
    int a;
    int b;
    int d;
    int w;
  } ev_t;

  ev_t evQ[$];
  int  busyQ[$];
  int  delayQ[$];
  int  plan[7];
  int  vectors = 0;
  int  miscompares = 0;
  int  enRises = 0;
  bit  noise = 1'b0;

  always #5 clk = ~clk;

  add_seq_ctrl #(
    .ROWS    (ROWS),
    .ACC_ROW (ACC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_row_i  (baseRow),
    .num_terms_i (numTerms),
    .add_done_i  (addDone),
    .add_en_o    (addEn),
    .src_a_sel_o (selA),
    .src_b_sel_o (selB),
    .dst_sel_o   (selD),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] rowBit(input int idx);
    logic [7:0] v;
    v = 8'd1 << idx;
    return v;
  endfunction

  // Reference: expand one request into the event sequence the controller owes us.
  task automatic modelRequest(input int base, input int num);
    int busyLen;
    bit reject;
    int w;
    busyLen = 1;
    reject  = (num < 2) || (base + num > ROWS) || (ACC >= base && ACC <= base + num - 1);
    if (reject) begin
      evQ.push_back('{EV_ERR, 0, 0, 0, 0});
      busyQ.push_back(1);
      return;
    end
    for (int k = 0; k < num - 1; k++) begin
      w = (plan[k] >= TIMEOUT) ? TIMEOUT : plan[k] + 1;
      delayQ.push_back(plan[k]);
      evQ.push_back('{EV_OP, (k == 0) ? base : ACC, base + k + 1, ACC, w});
      if (plan[k] >= TIMEOUT) begin
        evQ.push_back('{EV_ERR, 0, 0, 0, 0});
        busyQ.push_back(busyLen + 1 + TIMEOUT);
        return;
      end
      busyLen += 2 + w;
    end
    evQ.push_back('{EV_DONE, 0, 0, 0, 0});
    busyQ.push_back(busyLen + 1);
  endtask

  task automatic flushModel();
    evQ.delete();
    busyQ.delete();
    delayQ.delete();
  endtask

  task automatic applyStimulus(input int base, input int num, input bit nz);
    bit finished;
    finished = 1'b0;
    modelRequest(base, num);
    @(negedge clk);
    baseRow  = base[2:0];
    numTerms = num[3:0];
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    baseRow  = 3'($urandom);
    numTerms = 4'($urandom);
    noise    = nz;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = nz && busy && ($urandom_range(0, 3) == 0);
      if (start) begin
        baseRow  = 3'($urandom);
        numTerms = 4'($urandom);
      end
      if (evQ.size() == 0 && busyQ.size() == 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    noise = 1'b0;
    if (!finished) begin
      checkOutput("requestCompletes", 64'd0, 64'd1);
      flushModel();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic resetMidRun();
    int r0;
    for (int k = 0; k < 7; k++) plan[k] = 10;
    modelRequest(0, 4);
    r0 = enRises;
    @(negedge clk);
    baseRow  = 3'd0;
    numTerms = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && enRises < r0 + 2; c++) @(negedge clk);
    checkOutput("secondOpReached", 64'(enRises >= r0 + 2), 64'd1);
    #3 rst_n = 1'b0;
    #1 checkOutput("asyncResetOutputs", {addEn, selA, selB, selD, busy, done, err}, 64'd0);
    flushModel();
    repeat (2) @(negedge clk);
    checkOutput("heldResetOutputs", {addEn, selA, selB, selD, busy, done, err}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Model of the ADD FSM: answers each enable after the planned delay.
  initial begin
    int  dly;
    bit  pend;
    bit  prevEnR;
    dly = 0;
    pend = 1'b0;
    prevEnR = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        addDone = 1'b0;
        pend    = 1'b0;
        prevEnR = 1'b0;
      end else begin
        if (addEn && !prevEnR) begin
          dly  = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
          pend = 1'b1;
        end
        if (addEn && pend) begin
          if (dly == 0) begin
            addDone = 1'b1;
            pend    = 1'b0;
          end else begin
            addDone = 1'b0;
            dly--;
          end
        end else if (!addEn && noise) begin
          addDone = 1'($urandom_range(0, 1));
        end else begin
          addDone = 1'b0;
        end
        prevEnR = addEn;
      end
    end
  end

  // Monitor: pops expected events as the DUT presents them.
  initial begin
    bit          prevEn;
    bit          prevBusy;
    int          enCnt;
    int          lowCnt;
    int          busyCnt;
    int          opInTxn;
    logic [23:0] prevSel;
    logic [23:0] capSel;
    ev_t         e;
    prevEn = 1'b0;
    prevBusy = 1'b0;
    enCnt = 0;
    lowCnt = 0;
    busyCnt = 0;
    opInTxn = 0;
    prevSel = '0;
    capSel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevEn   = 1'b0;
        prevBusy = 1'b0;
        busyCnt  = 0;
        opInTxn  = 0;
        lowCnt   = 0;
        prevSel  = '0;
      end else begin
        if (!busy) checkOutput("selIdleZero", {selA, selB, selD}, 64'd0);
        checkOutput("selOnehot", 64'($onehot0(selA) && $onehot0(selB) && $onehot0(selD)), 64'd1);
        if (addEn && !prevEn) begin
          enRises++;
          if (opInTxn > 0) checkOutput("opGapCycles", 64'(lowCnt), 64'd2);
          checkOutput("selSetup", {selA, selB, selD}, prevSel);
          capSel = {selA, selB, selD};
          enCnt  = 1;
        end else if (addEn) begin
          enCnt++;
          checkOutput("selHold", {selA, selB, selD}, capSel);
        end else if (prevEn) begin
          lowCnt = 1;
          opInTxn++;
          if (evQ.size() == 0) begin
            checkOutput("opExpected", 64'd0, 64'd1);
          end else begin
            e = evQ.pop_front();
            checkOutput("opKind", 64'(e.kind), 64'(EV_OP));
            if (e.kind == EV_OP) begin
              checkOutput("srcA", capSel[23:16], rowBit(e.a));
              checkOutput("srcB", capSel[15:8], rowBit(e.b));
              checkOutput("dst", capSel[7:0], rowBit(e.d));
              checkOutput("waitCycles", 64'(enCnt), 64'(e.w));
            end
          end
        end else begin
          lowCnt++;
        end
        if (done || err) begin
          opInTxn = 0;
          if (evQ.size() == 0) begin
            checkOutput(done ? "doneExpected" : "errExpected", 64'd0, 64'd1);
          end else begin
            e = evQ.pop_front();
            checkOutput(done ? "doneKind" : "errKind", 64'(e.kind), done ? 64'(EV_DONE) : 64'(EV_ERR));
          end
        end
        if (busy) begin
          busyCnt++;
        end else if (prevBusy) begin
          if (busyQ.size() == 0) begin
            checkOutput("busyExpected", 64'd0, 64'd1);
          end else begin
            checkOutput("busyCycles", 64'(busyCnt), 64'(busyQ.pop_front()));
          end
          busyCnt = 0;
        end
        prevEn   = addEn;
        prevBusy = busy;
        prevSel  = {selA, selB, selD};
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int num;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {addEn, selA, selB, selD, busy, done, err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    plan = '{4, 4, 0, 0, 0, 0, 0};
    applyStimulus(0, 3, 1'b0);

    plan = '{0, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 1, 1'b0);
    applyStimulus(5, 4, 1'b0);
    applyStimulus(6, 2, 1'b0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 8, 1'b0);
    applyStimulus(0, 15, 1'b0);

    plan = '{1000, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 3, 1'b0);
    plan = '{2, 1000, 0, 0, 0, 0, 0};
    applyStimulus(1, 4, 1'b0);
    plan = '{63, 0, 0, 0, 0, 0, 0};
    applyStimulus(1, 2, 1'b0);

    plan = '{3, 1, 2, 0, 0, 0, 0};
    applyStimulus(2, 4, 1'b1);

    resetMidRun();
    plan = '{2, 3, 1, 0, 0, 0, 0};
    applyStimulus(0, 4, 1'b0);

    plan = '{0, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 7, 1'b0);

    for (int n = 0; n < 40; n++) begin
      base = $urandom_range(0, 7);
      num  = $urandom_range(0, 9);
      for (int k = 0; k < 7; k++) plan[k] = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) plan[$urandom_range(0, 6)] = ($urandom_range(0, 1) == 1) ? 1000 : 63;
      applyStimulus(base, num, 1'($urandom_range(0, 1)));
    end

    checkOutput("eventsDrained", 64'(evQ.size()), 64'd0);
    checkOutput("busyDrained", 64'(busyQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
